// File: rtl/phase_timer.sv
// phase_timer: per-phase interval timer that closes the traffic-light FSM loop.
// Returns one-cycle done pulses after each phase's programmed duration and reports the remaining seconds.
module phase_timer #(
  parameter int CLK_DIV = 50_000_000,
  parameter int T1      = 30,
  parameter int T2      = 5,
  parameter int T3      = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       C1,
  input  logic       C2,
  input  logic       C3,
  input  logic       pause,
  output logic       W1,
  output logic       W2,
  output logic       W3,
  output logic [7:0] sec_left,
  output logic       err
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  logic [2:0] en_d, en_q, w_d, w_q;
  logic [PW-1:0] pre_d, pre_q, pre_b;
  logic [7:0] sec_d, sec_q, sec_b, t_sel, sec_left_d, sec_left_q;
  logic active, start, sat, err_d, err_q;
  // elapsed time is kept as a prescaler plus whole seconds, so n = sec*CLK_DIV + pre
  always_comb begin
    en_d = {C1, C2, C3};
    active = $onehot(en_d);
    start = (en_d != en_q) || (|w_q);
    t_sel = C1 ? 8'(T1) : C2 ? 8'(T2) : 8'(T3);
    pre_b = start ? '0 : pre_q;
    sec_b = start ? '0 : sec_q;
    sat = (sec_b == t_sel) && (pre_b == '0);
    pre_d = !active ? '0 : (pause || sat) ? pre_b : (pre_b == PRE_MAX) ? '0 : pre_b + PW'(1);
    sec_d = !active ? '0 : (pause || sat || pre_b != PRE_MAX) ? sec_b : sec_b + 8'd1;
    w_d = (active && !pause && sec_d == t_sel && pre_d == '0) ? en_d : 3'b000;
    sec_left_d = active ? t_sel - sec_d : 8'd0;
    err_d = (en_d != 3'b000) && !active;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q <= '0;
      pre_q <= '0;
      sec_q <= '0;
      w_q <= '0;
      sec_left_q <= '0;
      err_q <= 1'b0;
    end else begin
      en_q <= en_d;
      pre_q <= pre_d;
      sec_q <= sec_d;
      w_q <= w_d;
      sec_left_q <= sec_left_d;
      err_q <= err_d;
    end
  end
  assign {W1, W2, W3} = w_q;
  assign sec_left = sec_left_q;
  assign err = err_q;
endmodule

// File: tb/tb_phase_timer.sv
// tb_phase_timer: directed checks of phase_timer with CLK_DIV=4, T1=3, T2=2, T3=5,
// plus a second instance with CLK_DIV=1, T2=1 for the degenerate divider.
module tb_phase_timer;
  logic clk = 0, reset = 1, c1 = 0, c2 = 0, c3 = 0, pause = 0;
  logic w1, w2, w3, err;
  logic [7:0] sec_left;
  logic d1 = 0, d2 = 0, d3 = 0;
  logic v1, v2, v3, verr;
  logic [7:0] vsec;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  phase_timer #(.CLK_DIV(4), .T1(3), .T2(2), .T3(5)) dut (
    .clk(clk), .reset(reset), .C1(c1), .C2(c2), .C3(c3), .pause(pause),
    .W1(w1), .W2(w2), .W3(w3), .sec_left(sec_left), .err(err)
  );

  phase_timer #(.CLK_DIV(1), .T2(1)) dut1 (
    .clk(clk), .reset(reset), .C1(d1), .C2(d2), .C3(d3), .pause(1'b0),
    .W1(v1), .W2(v2), .W3(v3), .sec_left(vsec), .err(verr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic [2:0] e);
    {c1, c2, c3} = e;
  endtask

  task automatic test_reset();
    #1 reset = 0;
    #1;
    vectors++;
    if ({w1, w2, w3, err, sec_left} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_initial: got %h expected 000", {w1, w2, w3, err, sec_left});
    end
    tick();
    reset = 1;
    set_en(3'b100);
    for (int k = 1; k <= 5; k++) tick();
    vectors++;
    if (sec_left !== 8'd2) begin
      miscompares++;
      $display("FAIL reset_precount: got %0d expected 2", sec_left);
    end
    #2 reset = 0;
    #1;
    vectors++;
    if ({w1, w2, w3, err, sec_left} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_async: got %h expected 000", {w1, w2, w3, err, sec_left});
    end
    #1 reset = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      vectors++;
      if (w1 !== (k == 12)) begin
        miscompares++;
        $display("FAIL reset_restart edge %0d: W1 got %b expected %b", k, w1, k == 12);
      end
    end
    set_en(3'b000);
    tick();
    tick();
  endtask

  task automatic test_countdown();
    logic [7:0] exp_sec [12] = '{8'd3, 8'd3, 8'd3, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0};
    set_en(3'b100);
    for (int k = 1; k <= 24; k++) begin
      tick();
      vectors++;
      if (sec_left !== exp_sec[(k - 1) % 12]) begin
        miscompares++;
        $display("FAIL countdown_sec edge %0d: got %0d expected %0d", k, sec_left, exp_sec[(k - 1) % 12]);
      end
      vectors++;
      if ({w1, w2, w3} !== ((k % 12 == 0) ? 3'b100 : 3'b000)) begin
        miscompares++;
        $display("FAIL countdown_w edge %0d: got %b expected %b", k, {w1, w2, w3}, (k % 12 == 0) ? 3'b100 : 3'b000);
      end
    end
    set_en(3'b000);
    tick();
  endtask

  task automatic test_closed_loop();
    logic [2:0] seq [4] = '{3'b100, 3'b010, 3'b001, 3'b010};
    logic [2:0] w, prev, exp_w;
    int st, last, np, exp_gap;
    st = 0; last = 0; np = 0; prev = 3'b000;
    set_en(seq[0]);
    for (int k = 1; k <= 140; k++) begin
      tick();
      w = {w1, w2, w3};
      vectors++;
      if ($countones(w) > 1) begin
        miscompares++;
        $display("FAIL loop_onehot cycle %0d: got %b expected at most one W", k, w);
      end
      if (w != 3'b000) begin
        exp_w = seq[np % 4];
        exp_gap = (np == 0) ? 12 : (exp_w == 3'b100) ? 13 : (exp_w == 3'b010) ? 9 : 21;
        vectors++;
        if (w !== exp_w || k - last != exp_gap) begin
          miscompares++;
          $display("FAIL loop_pulse %0d: got %b gap %0d expected %b gap %0d", np, w, k - last, exp_w, exp_gap);
        end
        last = k;
        np++;
      end
      if (prev != 3'b000) begin
        st = (st + 1) % 4;
        set_en(seq[st]);
      end
      prev = w;
    end
    vectors++;
    if (np != 10) begin
      miscompares++;
      $display("FAIL loop_count: got %0d pulses expected 10", np);
    end
    set_en(3'b000);
    tick();
    tick();
  endtask

  task automatic test_pause_switch();
    logic [7:0] exp_sec [13] = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0};
    set_en(3'b010);
    for (int k = 1; k <= 13; k++) begin
      tick();
      vectors++;
      if (sec_left !== exp_sec[k - 1] || {w1, w2, w3} !== ((k == 13) ? 3'b010 : 3'b000)) begin
        miscompares++;
        $display("FAIL pause edge %0d: got sec %0d W %b expected sec %0d W %b", k, sec_left, {w1, w2, w3}, exp_sec[k - 1], (k == 13) ? 3'b010 : 3'b000);
      end
      if (k == 3) pause = 1;
      if (k == 8) pause = 0;
    end
    set_en(3'b000);
    tick();
    set_en(3'b010);
    for (int k = 1; k <= 7; k++) tick();
    vectors++;
    if (sec_left !== 8'd1) begin
      miscompares++;
      $display("FAIL switch_pre: got %0d expected 1", sec_left);
    end
    set_en(3'b001);
    tick();
    vectors++;
    if ({w1, w2, w3} !== 3'b000 || sec_left !== 8'd5) begin
      miscompares++;
      $display("FAIL switch_edge: got W %b sec %0d expected W 000 sec 5", {w1, w2, w3}, sec_left);
    end
    for (int k = 9; k <= 27; k++) begin
      tick();
      vectors++;
      if ({w1, w2, w3} !== ((k == 27) ? 3'b001 : 3'b000)) begin
        miscompares++;
        $display("FAIL switch_run edge %0d: got %b expected %b", k, {w1, w2, w3}, (k == 27) ? 3'b001 : 3'b000);
      end
    end
    pause = 1;
    set_en(3'b100);
    for (int k = 28; k <= 29; k++) begin
      tick();
      vectors++;
      if ({w1, w2, w3} !== 3'b000 || sec_left !== 8'd3) begin
        miscompares++;
        $display("FAIL paused_start edge %0d: got W %b sec %0d expected W 000 sec 3", k, {w1, w2, w3}, sec_left);
      end
    end
    pause = 0;
    for (int k = 30; k <= 41; k++) begin
      tick();
      vectors++;
      if ({w1, w2, w3} !== ((k == 41) ? 3'b100 : 3'b000)) begin
        miscompares++;
        $display("FAIL resume edge %0d: got %b expected %b", k, {w1, w2, w3}, (k == 41) ? 3'b100 : 3'b000);
      end
    end
    set_en(3'b000);
    tick();
    tick();
  endtask

  task automatic test_illegal();
    set_en(3'b101);
    for (int k = 1; k <= 15; k++) begin
      tick();
      vectors++;
      if ({err, sec_left, w1, w2, w3} !== {1'b1, 8'd0, 3'b000}) begin
        miscompares++;
        $display("FAIL illegal edge %0d: got %h expected %h", k, {err, sec_left, w1, w2, w3}, {1'b1, 8'd0, 3'b000});
      end
    end
    set_en(3'b000);
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if ({err, sec_left, w1, w2, w3} !== 12'h000) begin
        miscompares++;
        $display("FAIL idle edge %0d: got %h expected 000", k, {err, sec_left, w1, w2, w3});
      end
    end
  endtask

  task automatic test_degenerate();
    d2 = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      vectors++;
      if ({v1, v2, v3, vsec} !== {3'b010, 8'd0}) begin
        miscompares++;
        $display("FAIL degenerate edge %0d: got %h expected %h", k, {v1, v2, v3, vsec}, {3'b010, 8'd0});
      end
    end
    d2 = 0;
    tick();
    vectors++;
    if ({v1, v2, v3} !== 3'b000) begin
      miscompares++;
      $display("FAIL degenerate_stop: got %b expected 000", {v1, v2, v3});
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_closed_loop();
    test_pause_switch();
    test_illegal();
    test_degenerate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
